// File: rtl/holoblade_pkg.sv
// Shared board-level definitions: system reset controller FSM encoding.
package holoblade_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABILISE = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_FAULT     = 2'd3;

  typedef enum logic [1:0] {
    StWaitLock  = ST_WAIT_LOCK,
    StStabilise = ST_STABILISE,
    StRun       = ST_RUN,
    StFault     = ST_FAULT
  } rst_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, async active-high reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two register stages to let metastability resolve before use.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sysclk_reset_ctrl.sv
// System reset controller: holds the board in reset until PLL lock has been stable,
// re-asserts reset for a fixed hold after lock loss, and drives a debug heartbeat.
module sysclk_reset_ctrl #(
  parameter int unsigned CLK_HZ          = 50250000,
  parameter int unsigned HEARTBEAT_HZ    = 1,
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOSS_CNT_W      = 8
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  pll_lock,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  heartbeat,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            state
);

  import holoblade_pkg::*;

  localparam int unsigned HB_DIV = CLK_HZ / (2 * HEARTBEAT_HZ);
  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int unsigned HB_W   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_DIV - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 2");
  end
  if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("RST_HOLD_CYCLES must be >= 1");
  end
  if (HB_DIV < 1) begin : g_bad_hb
    $error("HB_DIV must be >= 1");
  end

  logic lock_s;

  rst_state_e            state_q, state_d;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
  logic                  hb_q, hb_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i (sysclk),
    .rst_i (reset),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Next-state, counters and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = '0;
    hold_cnt_d = '0;
    loss_d     = loss_q;
    hb_cnt_d   = '0;
    hb_d       = 1'b0;

    unique case (state_q)
      StWaitLock: begin
        if (lock_s) state_d = StStabilise;
      end
      StStabilise: begin
        // Lock dropping takes priority over reaching the stable count.
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = StRun;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StFault;
          if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
        end
      end
      StFault: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = StWaitLock;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = StWaitLock;
    endcase

    // Divider only runs while staying in RUN; entering or leaving RUN clears it.
    if (state_q == StRun && state_d == StRun) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_W'(1);
        hb_d     = hb_q;
      end
    end

    sys_rst_d = (state_d != StRun);
  end

  // State, counters and registered outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= StWaitLock;
      stab_cnt_q <= '0;
      hold_cnt_q <= '0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ~sys_rst_d;
      loss_q     <= loss_d;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign heartbeat     = hb_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule
